// File: rtl/mtx_pkg.sv
// Shared definitions for the serial matrix link: cell types, component
// selectors and the fixed cell transmission order.
package mtx_pkg;

    localparam int CELL_W = 19;

    localparam logic REAL = 1'b0;
    localparam logic IMAG = 1'b1;

    typedef logic signed [CELL_W-1:0] cell_t;
    typedef cell_t [0:1][0:1][0:1]    mtx_t;

    typedef struct packed {
        logic row;
        logic col;
        logic imag;
    } tag_t;

    // Cell k of a transfer: row-major over the matrix, real before imaginary.
    function automatic tag_t cell_tag(input logic [2:0] k);
        tag_t t;
        t.row  = k[2];
        t.col  = k[1];
        t.imag = k[0];
        return t;
    endfunction

endpackage

// File: rtl/mtx_encoder.sv
// Matrix link transmitter: latches a 2x2 complex matrix on start and streams
// its 8 components out, one per ready strobe, with optional gaps and stall.
module mtx_encoder #(
    parameter int CELL_W = mtx_pkg::CELL_W,
    parameter int GAP    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [CELL_W-1:0] matrix_in [0:1][0:1][0:1],
    input  logic                     start,
    input  logic                     stall,
    output logic signed [CELL_W-1:0] matrix_cell,
    output logic                     imag,
    output logic                     row,
    output logic                     col,
    output logic                     ready,
    output logic                     busy,
    output logic                     done
);
    import mtx_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

    localparam logic [4:0] GAP_CNT   = 5'(GAP);
    localparam logic [4:0] GAP_ENTRY = (GAP == 0) ? 5'd0 : 5'd1;

    state_t                   state_q, state_d;
    logic [3:0]               next_k_q, next_k_d;  // next cell to issue; 8 once all are out
    logic [4:0]               gcnt_q, gcnt_d;
    logic signed [CELL_W-1:0] mtx_q [0:1][0:1][0:1];
    logic signed [CELL_W-1:0] cell_d;
    tag_t                     tag_d;
    logic                     accept, issue;
    logic [2:0]               k_iss;

    always_comb begin
        // NOTE: every combinational output is given a default first so no path infers a latch.
        state_d  = state_q;
        next_k_d = next_k_q;
        gcnt_d   = gcnt_q;
        cell_d   = matrix_cell;
        tag_d    = {row, col, imag};
        accept   = 1'b0;
        issue    = 1'b0;

        unique case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    accept = 1'b1;
                    if (stall) begin
                        state_d  = S_GAP;
                        next_k_d = 4'd0;
                        gcnt_d   = GAP_CNT;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (next_k_q == 4'd8) begin
                    state_d = S_FIN;
                end else if (GAP == 0 && !stall) begin
                    issue = 1'b1;
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = GAP_ENTRY;
                end
            end
            S_GAP: begin
                // Stall is only looked at once the gap count has run out.
                if (gcnt_q != GAP_CNT) begin
                    gcnt_d = gcnt_q + 5'd1;
                end else if (!stall) begin
                    issue = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        k_iss = accept ? 3'd0 : next_k_q[2:0];
        if (issue) begin
            state_d  = S_SEND;
            tag_d    = cell_tag(k_iss);
            cell_d   = accept ? matrix_in[0][0][0]
                              : mtx_q[tag_d.row][tag_d.col][tag_d.imag];
            next_k_d = {1'b0, k_iss} + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            next_k_q    <= '0;
            gcnt_q      <= '0;
            // NOTE: the matrix store is cleared on reset as well, so it never holds stale data.
            mtx_q       <= '{default: '0};
            matrix_cell <= '0;
            imag        <= 1'b0;
            row         <= 1'b0;
            col         <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_k_q    <= next_k_d;
            gcnt_q      <= gcnt_d;
            if (accept) mtx_q <= matrix_in;
            matrix_cell <= cell_d;
            row         <= tag_d.row;
            col         <= tag_d.col;
            imag        <= tag_d.imag;
            ready       <= issue;
            busy        <= (state_d == S_SEND) || (state_d == S_GAP);
            done        <= (state_d == S_FIN);
        end
    end

endmodule

// File: tb/tb_mtx_encoder.sv
// Self-checking bench for mtx_encoder: one instance with GAP=0 and one with
// GAP=2, each with an expected-cell queue consumed on every ready strobe.
module tb_mtx_encoder;
    import mtx_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance a: GAP=0
    logic signed [18:0] a_min [0:1][0:1][0:1];
    logic a_start = 1'b0, a_stall = 1'b0;
    logic signed [18:0] a_cell;
    logic a_imag, a_row, a_col, a_ready, a_busy, a_done;

    // Instance b: GAP=2
    logic signed [18:0] b_min [0:1][0:1][0:1];
    logic b_start = 1'b0, b_stall = 1'b0;
    logic signed [18:0] b_cell;
    logic b_imag, b_row, b_col, b_ready, b_busy, b_done;

    mtx_encoder #(.CELL_W(19), .GAP(0)) dut_a (
        .clk(clk), .reset(reset), .matrix_in(a_min), .start(a_start), .stall(a_stall),
        .matrix_cell(a_cell), .imag(a_imag), .row(a_row), .col(a_col),
        .ready(a_ready), .busy(a_busy), .done(a_done)
    );

    mtx_encoder #(.CELL_W(19), .GAP(2)) dut_b (
        .clk(clk), .reset(reset), .matrix_in(b_min), .start(b_start), .stall(b_stall),
        .matrix_cell(b_cell), .imag(b_imag), .row(b_row), .col(b_col),
        .ready(b_ready), .busy(b_busy), .done(b_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards of {row, col, imag, cell}
    logic [21:0] a_q[$];
    logic [21:0] b_q[$];
    int a_nready = 0, a_ndone = 0;
    int b_nready = 0, b_ndone = 0;

    always @(negedge clk) begin
        if (a_ready) begin
            a_nready++;
            if (a_q.size() == 0) check("a_unexpected_cell", 1, 0);
            else check("a_cell", {a_row, a_col, a_imag, a_cell}, a_q.pop_front());
        end
        if (a_done) a_ndone++;
    end

    always @(negedge clk) begin
        if (b_ready) begin
            b_nready++;
            if (b_q.size() == 0) check("b_unexpected_cell", 1, 0);
            else check("b_cell", {b_row, b_col, b_imag, b_cell}, b_q.pop_front());
        end
        if (b_done) b_ndone++;
    end

    function automatic logic [21:0] ent(input mtx_t m, input int k);
        logic [2:0] kk;
        kk = k[2:0];
        return {kk[2], kk[1], kk[0], m[kk[2]][kk[1]][kk[0]]};
    endfunction

    function automatic mtx_t mk(input int v0, input int v1, input int v2, input int v3,
                                input int v4, input int v5, input int v6, input int v7);
        mtx_t m;
        m[0][0][0] = cell_t'(v0); m[0][0][1] = cell_t'(v1);
        m[0][1][0] = cell_t'(v2); m[0][1][1] = cell_t'(v3);
        m[1][0][0] = cell_t'(v4); m[1][0][1] = cell_t'(v5);
        m[1][1][0] = cell_t'(v6); m[1][1][1] = cell_t'(v7);
        return m;
    endfunction

    function automatic mtx_t rnd();
        mtx_t m;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 2; i++)
                    m[r][c][i] = cell_t'($urandom);
        return m;
    endfunction

    task automatic load(input bit which, input mtx_t m);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 2; i++)
                    if (which) b_min[r][c][i] = m[r][c][i];
                    else       a_min[r][c][i] = m[r][c][i];
    endtask

    task automatic push(input bit which, input mtx_t m);
        for (int k = 0; k < 8; k++)
            if (which) b_q.push_back(ent(m, k));
            else       a_q.push_back(ent(m, k));
    endtask

    task automatic wait_done(input bit which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (which ? b_done : a_done) ok = 1'b1;
        end
    endtask

    function automatic logic [24:0] outs_a();
        return {a_cell, a_imag, a_row, a_col, a_ready, a_busy, a_done};
    endfunction

    function automatic logic [24:0] outs_b();
        return {b_cell, b_imag, b_row, b_col, b_ready, b_busy, b_done};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mtx_t m1, m3, m4, m5, m6, m7, m8, m9, m2;
        bit ok;
        int base_r, base_d;

        load(0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        load(1, mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset, then idle with start low
        repeat (3) begin
            @(negedge clk);
            check("reset_outs_a", outs_a(), 0);
            check("reset_outs_b", outs_b(), 0);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_outs_a", outs_a(), 0);
            check("idle_outs_b", outs_b(), 0);
        end

        // Basic transfer, GAP=0, including both 19-bit extremes
        m1 = mk(100, -100, 1, -1, 262143, -262144, 0, 7);
        load(0, m1); push(0, m1);
        base_r = a_nready; base_d = a_ndone;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("basic_ready_busy", {a_ready, a_busy, a_done}, 3'b110);
        end
        @(negedge clk); check("basic_done", {a_ready, a_busy, a_done}, 3'b001);
        @(negedge clk); check("basic_after", {a_ready, a_busy, a_done}, 3'b000);
        check("basic_ready_count", a_nready - base_r, 8);
        check("basic_done_count", a_ndone - base_d, 1);
        check("basic_sb_empty", a_q.size(), 0);

        // Gap and stall on the GAP=2 instance
        m2 = rnd();
        load(1, m2); push(1, m2);
        base_r = b_nready; base_d = b_ndone;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        check("gap_cell0", b_ready, 1);
        repeat (2) begin @(posedge clk); #1 check("gap_idle", b_ready, 0); end
        @(posedge clk); #1 check("gap_cell1", b_ready, 1);
        repeat (3) @(posedge clk); #1;
        check("gap_cell2", {b_ready, b_row, b_col, b_imag}, 4'b1010);
        b_stall = 1'b1;
        repeat (5) begin @(posedge clk); #1 check("stall_no_ready", b_ready, 0); end
        b_stall = 1'b0;
        @(posedge clk); #1 check("stall_resume_cell3", {b_ready, b_row, b_col, b_imag}, 4'b1011);
        wait_done(1, 40, ok);
        check("gap_done_seen", ok, 1);
        @(negedge clk); @(negedge clk);
        check("gap_ready_count", b_nready - base_r, 8);
        check("gap_done_count", b_ndone - base_d, 1);
        check("gap_sb_empty", b_q.size(), 0);

        // Start while busy, with matrix_in changed mid-transfer
        m3 = rnd(); m4 = rnd();
        load(0, m3); push(0, m3);
        base_r = a_nready; base_d = a_ndone;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        repeat (2) @(posedge clk); #1;
        load(0, m4); a_start = 1'b1;
        repeat (2) @(posedge clk); #1 a_start = 1'b0;
        wait_done(0, 20, ok);
        check("busy_done_seen", ok, 1);
        repeat (3) begin @(negedge clk); check("busy_after", {a_ready, a_busy, a_done}, 3'b000); end
        check("busy_ready_count", a_nready - base_r, 8);
        check("busy_done_count", a_ndone - base_d, 1);
        check("busy_sb_empty", a_q.size(), 0);

        // Back-to-back with start held high
        m5 = rnd(); m6 = rnd(); m7 = rnd();
        load(0, m5); push(0, m5); push(0, m6); push(0, m7);
        base_r = a_nready;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 load(0, m6);
        repeat (8) @(posedge clk); #1;
        check("b2b_done1", {a_ready, a_busy, a_done}, 3'b001);
        @(posedge clk); #1;
        check("b2b_first2", {a_ready, a_busy, a_done}, 3'b110);
        load(0, m7);
        repeat (8) @(posedge clk); #1;
        check("b2b_done2", {a_ready, a_busy, a_done}, 3'b001);
        @(posedge clk); #1;
        check("b2b_first3", {a_ready, a_busy, a_done}, 3'b110);
        a_start = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("b2b_done3", {a_ready, a_busy, a_done}, 3'b001);
        @(posedge clk); #1;
        check("b2b_end", {a_ready, a_busy, a_done}, 3'b000);
        check("b2b_ready_count", a_nready - base_r, 24);
        check("b2b_sb_empty", a_q.size(), 0);

        // Reset asserted during cell 5
        m8 = rnd();
        load(0, m8); push(0, m8);
        base_d = a_ndone;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("rst_cell5", {a_ready, a_row, a_col, a_imag}, 4'b1101);
        #2 reset = 1'b0;
        #1 check("rst_async_outs", outs_a(), 0);
        a_q.delete();
        repeat (3) begin @(negedge clk); check("rst_hold_outs", outs_a(), 0); end
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_done", a_ndone - base_d, 0);
        m9 = rnd();
        load(0, m9); push(0, m9);
        base_r = a_nready;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check("rst_restart_cell0", {a_ready, a_row, a_col, a_imag}, 4'b1000);
        wait_done(0, 20, ok);
        check("rst_restart_done", ok, 1);
        @(negedge clk);
        check("rst_restart_count", a_nready - base_r, 8);
        check("rst_restart_sb_empty", a_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtx_encoder.md
Name: mtx_encoder

Overview:
- Serialises one 2x2 complex matrix of 19-bit signed fixed-point cells into the serial matrix transmission. Each cell goes out with imag/row/col tags and a one-cycle ready strobe.
- Sits on the transmit side of the matrix link and feeds the matrix decoder on the far end.
- Captures a whole matrix on a start handshake, then emits 8 cells in fixed order with optional inter-cell gaps and a stall input.

Parameters:
- CELL_W, 19, width of one signed real or imaginary component.
- GAP, 0, idle cycles inserted after each emitted cell (0..15).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- matrix_in  input  signed [CELL_W-1:0] x [0:1][0:1][0:1]  source matrix, indexed [row][col][imag].
- start  input  1  request to transmit matrix_in; sampled only when busy=0.
- stall  input  1  back-pressure; while high, no new cell is emitted.
- matrix_cell  output  signed [CELL_W-1:0]  current cell value.
- imag  output  1  1 = imaginary component, 0 = real component.
- row  output  1  row index of current cell.
- col  output  1  column index of current cell.
- ready  output  1  one-cycle strobe; tags and matrix_cell are valid while high.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse after the last cell.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset=0) forces:
  - state to IDLE and the cell counter to 0;
  - the latched matrix to all zeros;
  - matrix_cell, imag, row, col, ready, busy and done to 0.
- Reset asserted mid-transfer aborts the transfer. No done pulse follows.
- States:
  - IDLE: waiting for start.
  - SEND: a cell is presented, ready=1.
  - GAP: inter-cell spacing, or waiting on stall.
  - FIN: done pulse.
- Cell order, counter k = 0..7: row=k[2], col=k[1], imag=k[0], matrix_cell = latched[row][col][imag]. Sequence is (0,0,R), (0,0,I), (0,1,R), (0,1,I), (1,0,R), (1,0,I), (1,1,R), (1,1,I).
- IDLE with start=1 and stall=0 at edge N:
  - latch all 8 cells of matrix_in;
  - set busy=1 and enter SEND;
  - the outputs after edge N present cell 0 with ready=1 (latency 0 cycles after the accepting edge).
- IDLE with start=1 and stall=1: start is accepted (matrix latched, busy=1). The first cell is held back in GAP until stall=0.
- SEND lasts exactly one cycle: ready=1, then ready returns to 0.
  - If k=7, go to FIN.
  - Otherwise go to GAP, or straight back to SEND if GAP=0 and stall=0.
- GAP: count GAP cycles, then wait for stall=0, then emit the next cell (k+1).
  - The stall input is sampled only at the edge that would issue a cell.
  - A stall arriving during the gap count does not extend the count.
  - Tags and matrix_cell hold their last values while ready=0.
- Uninterrupted transfer length: 8 + 7*GAP cycles of busy before FIN.
- FIN lasts one cycle: done=1, busy=0, return to IDLE. start is honoured in this cycle, so back-to-back transfers run with one idle-flag cycle between them.
- start while busy=1 is ignored. matrix_in changes after acceptance do not affect the transfer in progress.
- Values pass through unmodified. There is no arithmetic, saturation or sign change.

Decomposition:
- Shared package mtx_pkg, containing:
  - CELL_W = 19;
  - typedef cell_t (signed [CELL_W-1:0]);
  - typedef mtx_t (cell_t [0:1][0:1][0:1]);
  - localparams REAL=0 and IMAG=1;
  - the cell-order function k -> {row, col, imag}.
- Both encoder and decoder import mtx_pkg.
- No sub-module. The 8:1 cell mux stays inline.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then start=0 for 10 cycles -> all outputs 0 throughout.
- Basic transfer, GAP=0, no stall: matrix [0][0]={100,-100}, [0][1]={1,-1}, [1][0]={262143,-262144}, [1][1]={0,7}, start pulse -> 8 consecutive ready cycles in the order above with exact values, then done=1 one cycle later; busy high for exactly 8 cycles.
- Gap and stall, GAP=2: stall=1 for 5 cycles after the third cell -> that cell's successor appears on the first edge with stall=0 after the 2-cycle gap; total cell count 8, order intact; no ready while stall=1.
- Start while busy plus input change: second start at cell 3, matrix_in altered mid-transfer -> ignored; all 8 emitted values match the first latched matrix; exactly one done.
- Back-to-back: start held high continuously for 3 transfers with different matrices -> each transfer's first ready follows its done cycle by exactly one cycle; a scoreboard rebuilt from the tags matches each matrix.
- Reset mid-operation: reset=0 during cell 5 -> outputs zero immediately (asynchronously); no done; the next start transmits from cell 0 correctly.
